// File: rtl/seu_emr_cache_reader.sv
// Drains SEU EMR cache entries over the int/ack handshake into a small FIFO and streams them out.
// Optional capture timestamps: define SEU_EMR_CACHE_READER_TIMESTAMP_EN.
module seu_emr_cache_reader #(
  parameter int emr_data_width     = 35,
  parameter int fifo_depth         = 4,
  parameter int ack_holdoff_cycles = 2,
  parameter int count_width        = 16,
`ifdef SEU_EMR_CACHE_READER_TIMESTAMP_EN
  localparam int out_width         = emr_data_width + 32,
`else
  localparam int out_width         = emr_data_width,
`endif
  localparam int addr_width        = $clog2(fifo_depth),
  localparam int level_width       = addr_width + 1,
  localparam int hold_width        = $clog2(ack_holdoff_cycles + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      emr_cache_int,
  input  logic [emr_data_width-1:0] emr_data,
  output logic                      emr_cache_ack,
  output logic [out_width-1:0]      out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [level_width-1:0]    fifo_level,
  output logic [count_width-1:0]    event_count,
  output logic                      stall,
  input  logic                      stall_clr
);

  typedef enum logic [1:0] {IDLE, ACK, HOLDOFF} state_t;

  state_t                state, state_nxt;
  logic [hold_width-1:0] hold_cnt;
  logic [out_width-1:0]  mem [fifo_depth];
  logic [addr_width-1:0] wr_ptr, rd_ptr;
  logic                  full, push, pop, stall_set;
  logic [out_width-1:0]  entry;

`ifdef SEU_EMR_CACHE_READER_TIMESTAMP_EN
  logic [31:0] ts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + 32'd1;
  end

  assign entry = {ts, emr_data};
`else
  assign entry = emr_data;
`endif

  // Full check uses pre-edge occupancy, so a same-cycle pop never admits a push into a full FIFO.
  assign full      = (fifo_level == level_width'(fifo_depth));
  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_comb begin
    state_nxt     = state;
    emr_cache_ack = 1'b0;
    push          = 1'b0;
    stall_set     = 1'b0;
    case (state)
      IDLE: begin
        if (emr_cache_int) begin
          if (full) begin
            stall_set = 1'b1;
          end else begin
            push      = 1'b1;
            state_nxt = ACK;
          end
        end
      end
      ACK: begin
        emr_cache_ack = 1'b1;
        state_nxt     = HOLDOFF;
      end
      HOLDOFF: begin
        if (hold_cnt <= hold_width'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ACK)          hold_cnt <= hold_width'(ack_holdoff_cycles);
      else if (state == HOLDOFF) hold_cnt <= hold_cnt - hold_width'(1);
    end
  end

  // Storage carries data only; occupancy and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + addr_width'(1);
      if (pop)  rd_ptr <= rd_ptr + addr_width'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + level_width'(1);
        2'b01:   fifo_level <= fifo_level - level_width'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // A new stall condition outranks a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_count <= '0;
      stall       <= 1'b0;
    end else begin
      if (push && (event_count != '1)) event_count <= event_count + count_width'(1);
      if (stall_set)      stall <= 1'b1;
      else if (stall_clr) stall <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seu_emr_cache_reader.sv
// Bench for seu_emr_cache_reader: cycle table for fill/stall plus handshake, push/pop and reset sequences.
module tb_seu_emr_cache_reader;
  localparam int DW = 35;
`ifdef SEU_EMR_CACHE_READER_TIMESTAMP_EN
  localparam int OW = DW + 32;
`else
  localparam int OW = DW;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          emr_cache_int = 1'b0;
  logic [DW-1:0] emr_data = '0;
  logic          out_ready = 1'b0;
  logic          stall_clr = 1'b0;
  logic          emr_cache_ack;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic [2:0]    fifo_level;
  logic [15:0]   event_count;
  logic          stall;

  seu_emr_cache_reader dut (
    .clk(clk), .reset(reset), .emr_cache_int(emr_cache_int), .emr_data(emr_data),
    .emr_cache_ack(emr_cache_ack), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level), .event_count(event_count),
    .stall(stall), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW-1:0] sbq[$];
  int ack_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted beat must match the oldest expected entry.
  always @(negedge clk) begin
    #2;
    if (emr_cache_ack) ack_cyc.push_back(cyc);
    if (!reset && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else chk("sb_data", 64'(out_data[DW-1:0]), 64'(sbq.pop_front()));
    end
  end

  task automatic wait_ack(input int max, input string name);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk); #1;
      if (emr_cache_ack) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no ack within %0d cycles", name, max);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; emr_cache_int = 1'b0; out_ready = 1'b0; stall_clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    ack_cyc.delete();
  endtask

  task automatic capture_one(input logic [DW-1:0] d);
    @(negedge clk);
    emr_cache_int = 1'b1; emr_data = d; sbq.push_back(d);
    wait_ack(8, "cap_ack");
    @(negedge clk);
    emr_cache_int = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (!out_valid) break;
    end
    out_ready = 1'b0;
    chk(name, 64'(sbq.size()), 64'd0);
  endtask

  typedef struct {
    logic       intr;
    int         di;
    logic       rdy;
    logic       clr;
    logic       cap;
    logic       ack;
    logic       vld;
    logic [2:0] lvl;
    logic       stl;
  } vec_t;

  vec_t          vt[23];
  logic [DW-1:0] dv[5];

  task automatic setrow(input int k, input logic i, input int d, input logic r, input logic c,
                        input logic cp, input logic a, input logic v, input logic [2:0] l,
                        input logic s);
    vt[k] = '{i, d, r, c, cp, a, v, l, s};
  endtask

  initial begin
    dv[0] = 35'h0_1111_0001; dv[1] = 35'h2_2222_0002; dv[2] = 35'h3_3333_0003;
    dv[3] = 35'h4_4444_0004; dv[4] = 35'h5_5555_0005;
    //          k  int d  rdy clr | cap ack vld lvl stall
    setrow( 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    setrow( 1, 1, 0, 0, 0, 0, 1, 1, 1, 0);
    setrow( 2, 1, 1, 0, 0, 0, 0, 1, 1, 0);
    setrow( 3, 1, 1, 0, 0, 0, 0, 1, 1, 0);
    setrow( 4, 1, 1, 0, 0, 1, 0, 1, 1, 0);
    setrow( 5, 1, 1, 0, 0, 0, 1, 1, 2, 0);
    setrow( 6, 1, 2, 0, 0, 0, 0, 1, 2, 0);
    setrow( 7, 1, 2, 0, 0, 0, 0, 1, 2, 0);
    setrow( 8, 1, 2, 0, 0, 1, 0, 1, 2, 0);
    setrow( 9, 1, 2, 0, 0, 0, 1, 1, 3, 0);
    setrow(10, 1, 3, 0, 0, 0, 0, 1, 3, 0);
    setrow(11, 1, 3, 0, 0, 0, 0, 1, 3, 0);
    setrow(12, 1, 3, 0, 0, 1, 0, 1, 3, 0);
    setrow(13, 1, 3, 0, 0, 0, 1, 1, 4, 0);
    setrow(14, 1, 4, 0, 0, 0, 0, 1, 4, 0);
    setrow(15, 1, 4, 0, 0, 0, 0, 1, 4, 0);
    setrow(16, 1, 4, 0, 0, 0, 0, 1, 4, 0);
    setrow(17, 1, 4, 0, 1, 0, 0, 1, 4, 1);
    setrow(18, 0, 4, 0, 1, 0, 0, 1, 4, 1);
    setrow(19, 1, 4, 1, 0, 0, 0, 1, 4, 0);
    setrow(20, 1, 4, 0, 0, 1, 0, 1, 3, 1);
    setrow(21, 0, 4, 0, 1, 0, 1, 1, 4, 1);
    setrow(22, 0, 4, 0, 0, 0, 0, 1, 4, 0);

    // Reset values
    #1 reset = 1'b1;
    #2;
    chk("rst_ack", 64'(emr_cache_ack), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_count", 64'(event_count), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_out_data", 64'(out_data[DW-1:0]), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single event
    ack_cyc.delete();
    @(negedge clk);
    emr_cache_int = 1'b1; emr_data = 35'h1_2345_6789; sbq.push_back(35'h1_2345_6789);
    @(negedge clk);
    emr_cache_int = 1'b0;
    #1;
    chk("single_ack", 64'(emr_cache_ack), 64'd1);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data[DW-1:0]), 64'h1_2345_6789);
    chk("single_level", 64'(fifo_level), 64'd1);
    chk("single_count", 64'(event_count), 64'd1);
    @(negedge clk); #1;
    chk("single_ack_drop", 64'(emr_cache_ack), 64'd0);
    repeat (4) @(negedge clk);
    chk("single_ack_total", 64'(ack_cyc.size()), 64'd1);
    drain("single_drain");

    // Back-to-back events with int held high
    do_reset();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      emr_cache_int = 1'b1; emr_data = dv[n]; sbq.push_back(dv[n]);
      wait_ack(8, "b2b_ack");
    end
    @(negedge clk);
    emr_cache_int = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_ack_total", 64'(ack_cyc.size()), 64'd3);
    if (ack_cyc.size() == 3) begin
      chk("b2b_spacing0", 64'(ack_cyc[1] - ack_cyc[0]), 64'd4);
      chk("b2b_spacing1", 64'(ack_cyc[2] - ack_cyc[1]), 64'd4);
    end
    chk("b2b_count", 64'(event_count), 64'd3);
    chk("b2b_level", 64'(fifo_level), 64'd3);
    drain("b2b_drain");

    // Fill to full, stall behaviour and push/pop at full, cycle by cycle
    do_reset();
    for (int k = 0; k < 23; k++) begin
      @(negedge clk);
      emr_cache_int = vt[k].intr; emr_data = dv[vt[k].di];
      out_ready = vt[k].rdy; stall_clr = vt[k].clr;
      if (vt[k].cap) sbq.push_back(dv[vt[k].di]);
      #1;
      chk($sformatf("tbl%0d_ack", k), 64'(emr_cache_ack), 64'(vt[k].ack));
      chk($sformatf("tbl%0d_valid", k), 64'(out_valid), 64'(vt[k].vld));
      chk($sformatf("tbl%0d_level", k), 64'(fifo_level), 64'(vt[k].lvl));
      chk($sformatf("tbl%0d_stall", k), 64'(stall), 64'(vt[k].stl));
    end
    @(negedge clk);
    emr_cache_int = 1'b0; out_ready = 1'b0; stall_clr = 1'b0;
    chk("tbl_count", 64'(event_count), 64'd5);
    chk("tbl_ack_total", 64'(ack_cyc.size()), 64'd5);
    drain("tbl_drain");

    // Simultaneous push and pop at level 2
    do_reset();
    capture_one(35'h0_AAAA_000A);
    capture_one(35'h7_BBBB_000B);
    chk("pp_level_before", 64'(fifo_level), 64'd2);
    @(negedge clk);
    emr_cache_int = 1'b1; emr_data = 35'h6_CCCC_000C; out_ready = 1'b1;
    sbq.push_back(35'h6_CCCC_000C);
    @(negedge clk);
    emr_cache_int = 1'b0; out_ready = 1'b0;
    #1;
    chk("pp_level_after", 64'(fifo_level), 64'd2);
    chk("pp_ack", 64'(emr_cache_ack), 64'd1);
    chk("pp_head", 64'(out_data[DW-1:0]), 64'h7_BBBB_000B);
    repeat (3) @(negedge clk);
    drain("pp_drain");

    // Reset asserted during the ack cycle
    do_reset();
    @(negedge clk);
    emr_cache_int = 1'b1; emr_data = 35'h1_0000_0F0F;
    wait_ack(8, "rst_mid_ack_wait");
    reset = 1'b1; emr_cache_int = 1'b0;
    #1;
    chk("rstack_ack", 64'(emr_cache_ack), 64'd0);
    chk("rstack_valid", 64'(out_valid), 64'd0);
    chk("rstack_level", 64'(fifo_level), 64'd0);
    chk("rstack_count", 64'(event_count), 64'd0);
    @(negedge clk); #1;
    chk("rstack_hold_ack", 64'(emr_cache_ack), 64'd0);
    chk("rstack_hold_level", 64'(fifo_level), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rstack_post_ack", 64'(emr_cache_ack), 64'd0);
    chk("rstack_post_valid", 64'(out_valid), 64'd0);

`ifdef SEU_EMR_CACHE_READER_TIMESTAMP_EN
    // Timestamp of a capture on the tenth edge after reset release
    do_reset();
    repeat (10) @(negedge clk);
    emr_cache_int = 1'b1; emr_data = 35'h2_0000_1234; sbq.push_back(35'h2_0000_1234);
    @(negedge clk);
    emr_cache_int = 1'b0;
    #1;
    chk("ts_value", 64'(out_data[66:35]), 64'd10);
    chk("ts_data", 64'(out_data[DW-1:0]), 64'h2_0000_1234);
    repeat (3) @(negedge clk);
    drain("ts_drain");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
